// File: rtl/instr_mem_loadable.sv
// ---------------------------------------------------------------------------
// instr_mem_loadable
//   Instruction memory with a byte-serial program loader. In RUN it serves
//   fetches with one cycle of latency; a load_start switches to LOAD, where
//   little-endian bytes are packed into words and written sequentially from
//   word 0. The final byte (load_last) zero-pads and commits its word, then a
//   one-cycle FLUSH state pulses load_done and returns to RUN.
//
// Ports
//   clk, reset_n      clock, asynchronous active-low reset
//   a, req            fetch byte address and request
//   rd, rd_valid      fetched word and its valid flag (one cycle after req)
//   misaligned        response came from an address with a[1:0] != 0
//   load_start        begin a program load (honoured in RUN only)
//   load_byte/valid   program byte stream, little-endian within a word
//   load_last         marks the final byte of the image
//   load_ready        high while in LOAD
//   load_done         one-cycle pulse during FLUSH
//   load_ovf          sticky: image exceeded DEPTH words
// ---------------------------------------------------------------------------
module instr_mem_loadable #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] a,
    input  logic            req,
    output logic [XLEN-1:0] rd,
    output logic            rd_valid,
    output logic            misaligned,
    input  logic            load_start,
    input  logic [7:0]      load_byte,
    input  logic            load_valid,
    input  logic            load_last,
    output logic            load_ready,
    output logic            load_done,
    output logic            load_ovf
);

    localparam int unsigned IW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t          state;
    logic [XLEN-1:0] mem [DEPTH];

    // ptr has one extra bit so it can reach DEPTH, which marks "memory full".
    logic [IW:0]     ptr;
    logic [1:0]      byte_cnt;
    logic [XLEN-1:0] asm_word;

    logic            accept;
    logic            word_done;
    logic [XLEN-1:0] word_next;
    logic [IW-1:0]   idx;
    logic            out_of_range;

    always_comb begin
        accept       = (state == LOAD) && load_valid;
        // Bytes not yet received are still zero in asm_word, which gives
        // the zero padding of a short final word for free.
        word_next    = asm_word | (XLEN'(load_byte) << {byte_cnt, 3'b000});
        word_done    = accept && ((byte_cnt == 2'd3) || load_last);
        idx          = a[IW+1:2];
        out_of_range = (a >> (IW + 2)) != '0;
    end

    // Storage has no reset so that words survive a mid-load reset.
    always_ff @(posedge clk) begin
        if (word_done && !ptr[IW]) begin
            mem[ptr[IW-1:0]] <= word_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RUN;
            rd         <= '0;
            rd_valid   <= 1'b0;
            misaligned <= 1'b0;
            load_ready <= 1'b0;
            load_done  <= 1'b0;
            load_ovf   <= 1'b0;
            ptr        <= '0;
            byte_cnt   <= '0;
            asm_word   <= '0;
        end else begin
            rd_valid   <= 1'b0;
            misaligned <= 1'b0;
            load_done  <= 1'b0;
            case (state)
                RUN: begin
                    if (load_start) begin
                        // A req in the same cycle is deliberately dropped.
                        state      <= LOAD;
                        load_ready <= 1'b1;
                        ptr        <= '0;
                        byte_cnt   <= '0;
                        asm_word   <= '0;
                        load_ovf   <= 1'b0;
                    end else if (req) begin
                        rd_valid <= 1'b1;
                        if (a[1:0] != 2'b00) begin
                            rd         <= '0;
                            misaligned <= 1'b1;
                        end else if (out_of_range) begin
                            rd <= '0;
                        end else begin
                            rd <= mem[idx];
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (word_done) begin
                            byte_cnt <= '0;
                            asm_word <= '0;
                            if (ptr[IW]) begin
                                load_ovf <= 1'b1;
                            end else begin
                                ptr <= ptr + (IW + 1)'(1);
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                            asm_word <= word_next;
                        end
                        if (load_last) begin
                            state      <= FLUSH;
                            load_ready <= 1'b0;
                            load_done  <= 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    state <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// ---------------------------------------------------------------------------
// tb_instr_mem_loadable
//   Self-checking bench: directed loads and fetch tables for the documented
//   scenarios, plus random images and random fetches compared against a
//   byte-list memory model kept in the bench.
// ---------------------------------------------------------------------------
module tb_instr_mem_loadable;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 64;

    logic            clk;
    logic            reset_n;
    logic [XLEN-1:0] a;
    logic            req;
    logic [XLEN-1:0] rd;
    logic            rd_valid;
    logic            misaligned;
    logic            load_start;
    logic [7:0]      load_byte;
    logic            load_valid;
    logic            load_last;
    logic            load_ready;
    logic            load_done;
    logic            load_ovf;

    instr_mem_loadable #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .a          (a),
        .req        (req),
        .rd         (rd),
        .rd_valid   (rd_valid),
        .misaligned (misaligned),
        .load_start (load_start),
        .load_byte  (load_byte),
        .load_valid (load_valid),
        .load_last  (load_last),
        .load_ready (load_ready),
        .load_done  (load_done),
        .load_ovf   (load_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned passed = 0;
    int unsigned total  = 0;

    logic [31:0] model_mem [DEPTH];
    logic        model_ovf;
    logic [31:0] exp_rd;
    logic [7:0]  img [$];

    typedef struct {
        logic [31:0] addr;
        logic        rq;
        logic [31:0] rd;
        logic        valid;
        logic        mis;
    } fvec_t;

    fvec_t vec [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Image -> memory: word w is bytes 4w..4w+3 (little-endian, zero padded);
    // only the first DEPTH words fit, anything beyond flags overflow.
    task automatic model_load();
        int unsigned nw;
        logic [31:0] w;
        nw = (img.size() + 3) / 4;
        for (int unsigned i = 0; i < nw; i++) begin
            w = '0;
            for (int unsigned k = 0; k < 4; k++) begin
                if (4 * i + k < img.size()) w = w | (32'(img[4*i+k]) << (8 * k));
            end
            if (i < DEPTH) model_mem[i] = w;
        end
        model_ovf = (nw > DEPTH);
    endtask

    function automatic logic [32:0] model_fetch(input logic [31:0] addr);
        if (addr % 4 != 0) return {1'b1, 32'h0};
        if (addr >= 4 * DEPTH) return {1'b0, 32'h0};
        return {1'b0, model_mem[addr/4]};
    endfunction

    task automatic fetch(input logic [31:0] addr, input logic r, input string tag);
        logic [32:0] m;
        logic        emis;
        a   = addr;
        req = r;
        step();
        m    = model_fetch(addr);
        emis = 1'b0;
        if (r) begin
            exp_rd = m[31:0];
            emis   = m[32];
        end
        chk({tag, "_valid"}, 32'(rd_valid), 32'(r));
        chk({tag, "_rd"}, rd, exp_rd);
        chk({tag, "_mis"}, 32'(misaligned), 32'(emis));
        req = 1'b0;
    endtask

    // Streams img through the loader; req stays high throughout to show that
    // fetches are ignored outside RUN, and a stray load_start mid-load and in
    // FLUSH must have no effect.
    task automatic run_load(input bit gaps);
        int unsigned n;
        int unsigned completed;
        n = img.size();
        a = '0;
        req = 1'b1;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        chk("start_ready", 32'(load_ready), 32'd1);
        chk("start_ovf", 32'(load_ovf), 32'd0);
        chk("start_req_ignored", 32'(rd_valid), 32'd0);
        for (int unsigned i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                load_valid = 1'b0;
                step();
                chk("gap_ready", 32'(load_ready), 32'd1);
            end
            load_start = (i == 1);
            load_byte  = img[i];
            load_valid = 1'b1;
            load_last  = (i == n - 1);
            step();
            load_start = 1'b0;
            completed = (i == n - 1) ? (i + 4) / 4 : (i + 1) / 4;
            chk("byte_ovf", 32'(load_ovf), 32'(completed > DEPTH));
            chk("byte_rdv", 32'(rd_valid), 32'd0);
            if (i != n - 1) begin
                chk("byte_ready", 32'(load_ready), 32'd1);
                chk("byte_done", 32'(load_done), 32'd0);
            end else begin
                chk("last_done", 32'(load_done), 32'd1);
                chk("last_ready", 32'(load_ready), 32'd0);
            end
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        req = 1'b0;
        model_load();
        chk("post_done", 32'(load_done), 32'd0);
        chk("post_ready", 32'(load_ready), 32'd0);
        chk("post_rdv", 32'(rd_valid), 32'd0);
        chk("post_ovf", 32'(load_ovf), 32'(model_ovf));
    endtask

    initial begin
        for (int unsigned i = 0; i < DEPTH; i++) model_mem[i] = '0;
        model_ovf  = 1'b0;
        exp_rd     = '0;
        reset_n    = 1'b0;
        a          = '0;
        req        = 1'b0;
        load_start = 1'b0;
        load_byte  = '0;
        load_valid = 1'b0;
        load_last  = 1'b0;

        vec[0] = '{32'h0000_0004, 1'b1, 32'h1000_0593, 1'b1, 1'b0};
        vec[1] = '{32'h0000_0004, 1'b0, 32'h1000_0593, 1'b0, 1'b0};
        vec[2] = '{32'h0000_0006, 1'b1, 32'h0000_0000, 1'b1, 1'b1};
        vec[3] = '{32'h0000_0100, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vec[4] = '{32'h0000_0000, 1'b1, 32'h0010_0513, 1'b1, 1'b0};
        vec[5] = '{32'h0000_0000, 1'b0, 32'h0010_0513, 1'b0, 1'b0};
        vec[6] = '{32'h0000_0003, 1'b1, 32'h0000_0000, 1'b1, 1'b1};
        vec[7] = '{32'h8000_0004, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vec[8] = '{32'h0000_0102, 1'b1, 32'h0000_0000, 1'b1, 1'b1};

        // Reset state
        step();
        step();
        chk("rst_rd", rd, 32'h0);
        chk("rst_rdv", 32'(rd_valid), 32'd0);
        chk("rst_mis", 32'(misaligned), 32'd0);
        chk("rst_ready", 32'(load_ready), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_ovf", 32'(load_ovf), 32'd0);
        reset_n = 1'b1;
        step();

        // Overflowing image: every word gets written, extra word is dropped
        img.delete();
        for (int unsigned i = 0; i < DEPTH * 4 + 4; i++) img.push_back(8'($urandom));
        run_load(1'b0);
        chk("ovf_sticky", 32'(load_ovf), 32'd1);
        for (int unsigned w = 0; w < DEPTH; w++) fetch(32'(4 * w), 1'b1, "ovf_word");

        // Two-word program
        img = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h00, 8'h10};
        run_load(1'b0);
        chk("prog_ovf_cleared", 32'(load_ovf), 32'd0);
        for (int unsigned i = 0; i < 9; i++) begin
            a   = vec[i].addr;
            req = vec[i].rq;
            step();
            chk("tab_valid", 32'(rd_valid), 32'(vec[i].valid));
            chk("tab_rd", rd, vec[i].rd);
            chk("tab_mis", 32'(misaligned), 32'(vec[i].mis));
        end
        req = 1'b0;
        exp_rd = vec[8].rd;

        // Five bytes: second word is zero padded
        img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        run_load(1'b1);
        fetch(32'h0, 1'b1, "pad_w0");
        chk("pad_w0_const", rd, 32'hDDCC_BBAA);
        fetch(32'h4, 1'b1, "pad_w1");
        chk("pad_w1_const", rd, 32'h0000_00EE);

        // Random images and random fetches against the model
        for (int unsigned t = 0; t < 4; t++) begin
            img.delete();
            for (int unsigned i = 0; i < $urandom_range(1, 24); i++) img.push_back(8'($urandom));
            run_load(1'b1);
            for (int unsigned f = 0; f < 40; f++) begin
                logic [31:0] ad;
                case ($urandom_range(0, 3))
                    0, 1:    ad = 32'(4 * $urandom_range(0, 7));
                    2:       ad = 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
                    default: ad = $urandom | 32'(4 * DEPTH);
                endcase
                fetch(ad, (f == 0) ? 1'b1 : 1'($urandom_range(0, 1)), "rnd");
            end
        end

        // Reset after six accepted bytes: word 0 kept, partial word lost
        img.delete();
        for (int unsigned i = 0; i < 6; i++) img.push_back(8'($urandom));
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int unsigned i = 0; i < 6; i++) begin
            load_byte  = img[i];
            load_valid = 1'b1;
            step();
        end
        load_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_rd", rd, 32'h0);
        chk("mid_rst_rdv", 32'(rd_valid), 32'd0);
        chk("mid_rst_ready", 32'(load_ready), 32'd0);
        chk("mid_rst_done", 32'(load_done), 32'd0);
        chk("mid_rst_ovf", 32'(load_ovf), 32'd0);
        exp_rd = '0;
        while (img.size() > 4) void'(img.pop_back());
        model_load();
        step();
        reset_n = 1'b1;
        step();
        chk("after_rst_ready", 32'(load_ready), 32'd0);
        fetch(32'h0, 1'b1, "mid_rst_w0");
        fetch(32'h4, 1'b1, "mid_rst_w1");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
